rob_commit: RTL
===============

# rob_commit

In-order retirement unit (reorder buffer) at the far end of the issue/CDB/commit protocol of the out-of-order core. It allocates tags at issue and captures results broadcast on the GPR and FPR CDBs. It retires the oldest entry each cycle into the architectural register files and drives the store-commit handshake consumed by the load/store unit. It also answers operand lookups by tag so issue logic can read completed-but-uncommitted values.

## Interface
- ROB_WIDTH, 4, tag width; DEPTH = 2**ROB_WIDTH entries, tag = entry index
- DATA_WIDTH, 32, result width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- issue_valid  in  1  issue request
- issue_ready  out  1  entry available
- issue_is_store  in  1  entry is a store (no register destination)
- issue_has_dest  in  1  entry writes a register
- issue_dest_fpr  in  1  destination is FPR (0: GPR)
- issue_dest_reg  in  5  destination register index
- issue_tag  out  ROB_WIDTH  tag allocated to the issuing instruction (= tail)
- gpr_cdb_valid / fpr_cdb_valid  in  1 each  CDB broadcast
- gpr_cdb_tag / fpr_cdb_tag  in  ROB_WIDTH each  broadcast tag
- gpr_cdb_data / fpr_cdb_data  in  DATA_WIDTH each  broadcast data
- sw_done_valid  in  1  store unit reports a store's address and data resolved
- sw_done_tag  in  ROB_WIDTH  tag of that store
- lookup_tag[1:0]  in  ROB_WIDTH each  operand lookup tags
- lookup_valid[1:0]  out  1 each  value available
- lookup_data[1:0]  out  DATA_WIDTH each  value
- commit_valid  out  1  register write this cycle
- commit_fpr  out  1  write targets FPR
- commit_reg  out  5  register index
- commit_tag  out  ROB_WIDTH  retiring tag (register files clear their busy tag on match)
- commit_data  out  DATA_WIDTH  value written
- sw_commit_valid  out  1  head is a resolved store, request memory write
- sw_commit_ready  in  1  store unit accepts
- count  out  ROB_WIDTH+1  occupied entries

## Operation
- Per entry: done, is_store, has_dest, dest_fpr, dest_reg, data. head, tail: ROB_WIDTH-bit, wrap modulo DEPTH; count disambiguates full/empty.
- Issue fires on issue_valid && issue_ready: write entry[tail] with done=0, data=X; tail+1.
- issue_ready = count != DEPTH || commit_fire.
- Completion: GPR CDB sets done/data of entry gpr_cdb_tag; FPR CDB likewise for fpr_cdb_tag; sw_done sets done of a store entry. Broadcasts to unoccupied entries are ignored. Both CDBs may hit different entries in one cycle; same tag on both CDBs is illegal (simulation error message).
- Head retire condition: count != 0 && entry[head].done.
  - Non-store: commit_valid = has_dest; fires unconditionally; entries without dest retire silently.
  - Store: sw_commit_valid = 1; fires only when sw_commit_ready.
- commit_fire pops head: head+1, count-1. At most one retire per cycle.
- count_next = count + issue_fire - commit_fire; simultaneous issue and retire when full is allowed (count stays DEPTH).
- Lookup: lookup_valid = entry done, or a CDB this cycle carries the same tag (data bypassed from that CDB, GPR priority). Lookup of a tag not occupied: lookup_valid=0, data X.

## Timing
- Reset: head=tail=count=0, all done=0; commit_valid=0, sw_commit_valid=0, issue_ready=1, issue_tag=0, lookup_valid=0.
- issue_tag, lookup outputs combinational; commit outputs combinational from registered state (no input-to-commit path except sw_commit_ready→issue_ready).
- CDB in cycle N → entry done at N+1 → earliest commit in cycle N+1; lookup sees the value in cycle N via bypass.
- Issue in cycle N, matching CDB earliest N+1.
- sw_commit_valid held stable until sw_commit_ready; never retracted while head unchanged.
- Reset mid-operation discards all entries next edge; no commit fires in the reset cycle.

## Test plan
- Reset, issue 3 GPR ops (reg 1,2,3) → tags 0,1,2, count=3; CDB tags 2,0,1 with 0xA,0xB,0xC → commits in order reg1=0xB, reg2=0xC, reg3=0xA, one per cycle.
- Fill 16 entries → issue_ready=0; complete head same cycle as a new issue → issue accepted, count stays 16, tag wraps to 0.
- Store at head, done, sw_commit_ready=0 for 3 cycles → sw_commit_valid held, head unchanged; ready=1 → retires, commit_valid stays 0.
- Lookup tag 5 while gpr_cdb broadcasts tag 5 data 0x1234 → lookup_valid=1, data 0x1234 same cycle.
- GPR CDB tag 1 and FPR CDB tag 2 same cycle → both done; fpr entry commits with commit_fpr=1.
- Reset with 5 entries pending → count=0, commit_valid=0 next cycle, next issue_tag=0.

Source files
------------

// File: rtl/rob_commit.sv
// In-order reorder buffer: allocates tags at issue, captures CDB and store-done results,
// retires the oldest completed entry per cycle and serves tag-indexed operand lookups.
module rob_commit #(
    parameter int ROB_WIDTH  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_issue_valid,
    output logic                  o_issue_ready,
    input  logic                  i_issue_is_store,
    input  logic                  i_issue_has_dest,
    input  logic                  i_issue_dest_fpr,
    input  logic [4:0]            i_issue_dest_reg,
    output logic [ROB_WIDTH-1:0]  o_issue_tag,
    input  logic                  i_gpr_cdb_valid,
    input  logic [ROB_WIDTH-1:0]  i_gpr_cdb_tag,
    input  logic [DATA_WIDTH-1:0] i_gpr_cdb_data,
    input  logic                  i_fpr_cdb_valid,
    input  logic [ROB_WIDTH-1:0]  i_fpr_cdb_tag,
    input  logic [DATA_WIDTH-1:0] i_fpr_cdb_data,
    input  logic                  i_sw_done_valid,
    input  logic [ROB_WIDTH-1:0]  i_sw_done_tag,
    input  logic [ROB_WIDTH-1:0]  i_lookup_tag0,
    input  logic [ROB_WIDTH-1:0]  i_lookup_tag1,
    output logic                  o_lookup_valid0,
    output logic                  o_lookup_valid1,
    output logic [DATA_WIDTH-1:0] o_lookup_data0,
    output logic [DATA_WIDTH-1:0] o_lookup_data1,
    output logic                  o_commit_valid,
    output logic                  o_commit_fpr,
    output logic [4:0]            o_commit_reg,
    output logic [ROB_WIDTH-1:0]  o_commit_tag,
    output logic [DATA_WIDTH-1:0] o_commit_data,
    output logic                  o_sw_commit_valid,
    input  logic                  i_sw_commit_ready,
    output logic [ROB_WIDTH:0]    o_count
);
    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] FULL = (ROB_WIDTH+1)'(DEPTH);

    logic [ROB_WIDTH-1:0]  r_head;
    logic [ROB_WIDTH-1:0]  r_tail;
    logic [ROB_WIDTH:0]    r_count;
    logic                  r_done     [DEPTH];
    logic                  r_is_store [DEPTH];
    logic                  r_has_dest [DEPTH];
    logic                  r_dest_fpr [DEPTH];
    logic [4:0]            r_dest_reg [DEPTH];
    logic [DATA_WIDTH-1:0] r_data     [DEPTH];

    logic                  w_head_done;
    logic                  w_commit_fire;
    logic                  w_issue_fire;
    logic [ROB_WIDTH:0]    w_count_next;
    logic                  w_gpr_wr;
    logic                  w_fpr_wr;
    logic                  w_sw_wr;

    // Occupied when the distance from head (mod DEPTH) is below the occupancy count.
    function automatic logic f_occ(input logic [ROB_WIDTH-1:0] tag,
                                   input logic [ROB_WIDTH-1:0] head,
                                   input logic [ROB_WIDTH:0]   cnt);
        logic [ROB_WIDTH-1:0] off;
        off = tag - head;
        return {1'b0, off} < cnt;
    endfunction

    // Reset gates the retire outputs so the register files never see a write in the reset cycle.
    assign w_head_done       = (r_count != '0) && r_done[r_head];
    assign w_commit_fire     = !reset && w_head_done && (!r_is_store[r_head] || i_sw_commit_ready);
    assign o_commit_valid    = !reset && w_head_done && !r_is_store[r_head] && r_has_dest[r_head];
    assign o_sw_commit_valid = !reset && w_head_done && r_is_store[r_head];
    assign o_commit_fpr      = r_dest_fpr[r_head];
    assign o_commit_reg      = r_dest_reg[r_head];
    assign o_commit_tag      = r_head;
    assign o_commit_data     = r_data[r_head];

    assign o_issue_ready = (r_count != FULL) || w_commit_fire;
    assign w_issue_fire  = !reset && i_issue_valid && o_issue_ready;
    assign o_issue_tag   = r_tail;
    assign o_count       = r_count;

    assign w_gpr_wr = i_gpr_cdb_valid && f_occ(i_gpr_cdb_tag, r_head, r_count);
    assign w_fpr_wr = i_fpr_cdb_valid && f_occ(i_fpr_cdb_tag, r_head, r_count);
    assign w_sw_wr  = i_sw_done_valid && f_occ(i_sw_done_tag, r_head, r_count)
                      && r_is_store[i_sw_done_tag];

    always_comb begin
        w_count_next = r_count;
        case ({w_issue_fire, w_commit_fire})
            2'b10:   w_count_next = r_count + (ROB_WIDTH+1)'(1);
            2'b01:   w_count_next = r_count - (ROB_WIDTH+1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Lookup bypass: a same-cycle CDB hit wins over stored data, GPR before FPR.
    always_comb begin
        o_lookup_valid0 = f_occ(i_lookup_tag0, r_head, r_count) &&
                          (r_done[i_lookup_tag0] ||
                           (i_gpr_cdb_valid && i_gpr_cdb_tag == i_lookup_tag0) ||
                           (i_fpr_cdb_valid && i_fpr_cdb_tag == i_lookup_tag0));
        o_lookup_data0  = r_data[i_lookup_tag0];
        if (i_fpr_cdb_valid && i_fpr_cdb_tag == i_lookup_tag0) o_lookup_data0 = i_fpr_cdb_data;
        if (i_gpr_cdb_valid && i_gpr_cdb_tag == i_lookup_tag0) o_lookup_data0 = i_gpr_cdb_data;

        o_lookup_valid1 = f_occ(i_lookup_tag1, r_head, r_count) &&
                          (r_done[i_lookup_tag1] ||
                           (i_gpr_cdb_valid && i_gpr_cdb_tag == i_lookup_tag1) ||
                           (i_fpr_cdb_valid && i_fpr_cdb_tag == i_lookup_tag1));
        o_lookup_data1  = r_data[i_lookup_tag1];
        if (i_fpr_cdb_valid && i_fpr_cdb_tag == i_lookup_tag1) o_lookup_data1 = i_fpr_cdb_data;
        if (i_gpr_cdb_valid && i_gpr_cdb_tag == i_lookup_tag1) o_lookup_data1 = i_gpr_cdb_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_done[i] <= 1'b0;
        end else begin
            if (w_gpr_wr) begin
                r_done[i_gpr_cdb_tag] <= 1'b1;
                r_data[i_gpr_cdb_tag] <= i_gpr_cdb_data;
            end
            if (w_fpr_wr) begin
                r_done[i_fpr_cdb_tag] <= 1'b1;
                r_data[i_fpr_cdb_tag] <= i_fpr_cdb_data;
            end
            if (w_sw_wr) r_done[i_sw_done_tag] <= 1'b1;
            if (w_commit_fire) r_head <= r_head + ROB_WIDTH'(1);
            // Issue is written last: when full with a retire, tail aliases the departing head.
            if (w_issue_fire) begin
                r_done[r_tail]     <= 1'b0;
                r_is_store[r_tail] <= i_issue_is_store;
                r_has_dest[r_tail] <= i_issue_has_dest;
                r_dest_fpr[r_tail] <= i_issue_dest_fpr;
                r_dest_reg[r_tail] <= i_issue_dest_reg;
                r_tail             <= r_tail + ROB_WIDTH'(1);
            end
            r_count <= w_count_next;
        end
    end

    a_cdb_tag_clash: assert property (@(posedge clk) disable iff (reset)
        !(i_gpr_cdb_valid && i_fpr_cdb_valid && i_gpr_cdb_tag == i_fpr_cdb_tag))
        else $error("rob_commit: GPR and FPR CDB broadcast the same tag %0d", i_gpr_cdb_tag);

endmodule
